// File: rtl/sparrow_writeback.sv
// sparrow_writeback: final stage before the register file write port.
// ALU results and extended load results share one registered write port.
// Loads are queued in a small FIFO; a wait counter on the FIFO head forces
// a load through once it has been passed over STARVE_MAX times.
module sparrow_writeback #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [1:0]  lsu_byte_off_i,
  output logic        lsu_pending_o,
  output logic [4:0]  rd_addr_o,
  output logic        wr_en_o,
  output logic [31:0] wr_data_o
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);

  logic [4:0]       fifo_rd   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [WAIT_W-1:0] wait_cnt;

  logic        fifo_has;
  logic        force_load;
  logic        alu_xfer;
  logic        push;
  logic        pop;
  logic        sel;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Byte/half extraction of the raw word, done before the entry is queued.
  always_comb begin
    ld_byte = lsu_data_i[{lsu_byte_off_i, 3'b000} +: 8];
    ld_half = lsu_data_i[{lsu_byte_off_i[1], 4'b0000} +: 16];
    ld_ext  = lsu_data_i;
    case (lsu_funct3_i)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = lsu_data_i;
    endcase
  end

  // Arbitration: ALU wins unless the queued load has starved; otherwise drain the FIFO head.
  always_comb begin
    fifo_has    = (count != '0);
    force_load  = fifo_has && (wait_cnt == WAIT_W'(STARVE_MAX));
    alu_ready_o = !reset && !force_load;
    lsu_ready_o = !reset && (count != CNT_W'(DEPTH));
    alu_xfer    = alu_valid_i && alu_ready_o;
    push        = lsu_valid_i && lsu_ready_o;
    pop         = !reset && !alu_xfer && fifo_has;
    sel         = alu_xfer || pop;
    sel_rd      = alu_xfer ? alu_rd_i   : fifo_rd[head];
    sel_data    = alu_xfer ? alu_data_i : fifo_data[head];
  end

  assign lsu_pending_o = (count != '0);

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= lsu_rd_i;
      fifo_data[tail] <= ld_ext;
    end
  end

  // FIFO pointers, occupancy and head wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) tail <= ptr_next(tail);
      if (pop)  head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop || !fifo_has)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(STARVE_MAX))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Registered write port; x0 destinations are consumed but never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_o   <= 1'b0;
      rd_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_en_o <= sel && (sel_rd != 5'd0);
      if (sel) begin
        rd_addr_o <= sel_rd;
        wr_data_o <= sel_data;
      end
    end
  end

endmodule
